// File: rtl/shmem_pkg.sv
// Shared scratchpad port scheduler: common types and helpers.
package shmem_pkg;

  localparam int COUNT_DEF     = 4;
  localparam int BUS_SIZE_DEF  = 128;
  localparam int ADDR_W_DEF    = 8;
  localparam int MAX_BURST_DEF = 4;

  typedef logic [ADDR_W_DEF-1:0]   addr_t;
  typedef logic [BUS_SIZE_DEF-1:0] data_t;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} ch_state_e;

  // Beat counter has to hold MAX_BURST itself (it saturates there under lock).
  function automatic int beat_cnt_w(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/shmem_rr_channel.sv
// One round-robin arbitration channel with burst-hold grants.
// Grant is registered (one cycle arbitration latency); mask suppresses the
// grant for a cycle without consuming a beat; lock holds ownership.
module shmem_rr_channel
  import shmem_pkg::*;
#(
  parameter int  N         = 4,
  parameter int  MAX_BURST = 4,
  localparam int OW        = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  lock,
  input  logic          mask,
  output logic [N-1:0]  gnt,
  output logic [OW-1:0] owner,
  output logic          beat
);

  localparam int CW = beat_cnt_w(MAX_BURST);

  ch_state_e     state;
  logic [N-1:0]  gnt_q;
  logic [N-1:0]  others;
  logic [OW-1:0] ptr_q, nxt_ptr, pick_idle, pick_rel;
  logic [CW-1:0] cnt_q;
  logic          own_req, own_lock, last, rel;

  function automatic logic [N-1:0] onehot(input logic [OW-1:0] idx);
    logic [N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // First set bit of r at or after p, wrapping; p if r is empty.
  function automatic logic [OW-1:0] rr_pick(input logic [N-1:0] r, input logic [OW-1:0] p);
    logic [OW-1:0] sel;
    logic          found;
    int            k;
    sel   = p;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      k = (int'(p) + i) % N;
      if (!found && r[k[OW-1:0]]) begin
        sel   = k[OW-1:0];
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign own_req   = req[owner];
  assign own_lock  = lock[owner];
  assign beat      = gnt_q[owner] & ~mask & own_req;
  assign last      = beat & (int'(cnt_q) >= MAX_BURST - 1);
  assign rel       = (state == GRANT) & ~own_lock & (~own_req | last);
  assign nxt_ptr   = (int'(owner) == N - 1) ? '0 : owner + 1'b1;
  // The releasing owner is excluded so a lone requester sees an idle gap.
  assign others    = req & ~onehot(owner);
  assign pick_idle = rr_pick(req, ptr_q);
  assign pick_rel  = rr_pick(others, nxt_ptr);
  assign gnt       = gnt_q & ~{N{mask}};

  // Channel FSM: pick, hold for a burst, hand over without a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt_q <= '0;
      owner <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state <= GRANT;
            owner <= pick_idle;
            gnt_q <= onehot(pick_idle);
            cnt_q <= '0;
          end
        end
        GRANT: begin
          if (rel) begin
            ptr_q <= nxt_ptr;
            cnt_q <= '0;
            if (|others) begin
              owner <= pick_rel;
              gnt_q <= onehot(pick_rel);
            end else begin
              state <= IDLE;
              gnt_q <= '0;
            end
          end else if (beat && int'(cnt_q) < MAX_BURST) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/shmem_port_sched.sv
// Shared scratchpad port scheduler: independent read/write round-robin
// channels, same-address hazard stall (write wins) and read-data return.
// Optional feature: define SHMEM_LOCK_EN to add i_rd_lock/i_wr_lock grant locks.
module shmem_port_sched
  import shmem_pkg::*;
#(
  parameter int COUNT     = COUNT_DEF,
  parameter int BUS_SIZE  = BUS_SIZE_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [COUNT-1:0]    i_rd_req,
  input  logic [ADDR_W-1:0]   i_rd_addr [COUNT],
  output logic [COUNT-1:0]    o_rd_gnt,
  output logic [COUNT-1:0]    o_rd_vld,
  output logic [BUS_SIZE-1:0] o_rd_data,
  input  logic [COUNT-1:0]    i_wr_req,
  input  logic [ADDR_W-1:0]   i_wr_addr [COUNT],
  input  logic [BUS_SIZE-1:0] i_wr_data [COUNT],
  output logic [COUNT-1:0]    o_wr_gnt,
`ifdef SHMEM_LOCK_EN
  input  logic [COUNT-1:0]    i_rd_lock,
  input  logic [COUNT-1:0]    i_wr_lock,
`endif
  output logic [ADDR_W-1:0]   o_mem_rd_addr,
  input  logic [BUS_SIZE-1:0] i_mem_rd_data,
  output logic [ADDR_W-1:0]   o_mem_wr_addr,
  output logic [BUS_SIZE-1:0] o_mem_wr_data,
  output logic                o_mem_wr_en
);

  localparam int OW = $clog2(COUNT);

  logic [COUNT-1:0] rd_lock, wr_lock;
  logic [OW-1:0]    rd_own, wr_own, rd_own_q;
  logic             rd_beat, wr_beat, hazard, rd_vld_q;

`ifdef SHMEM_LOCK_EN
  assign rd_lock = i_rd_lock;
  assign wr_lock = i_wr_lock;
`else
  assign rd_lock = '0;
  assign wr_lock = '0;
`endif

  // Write beat and read owner hitting the same word: read slips a cycle so it sees the new data.
  assign hazard = wr_beat & i_rd_req[rd_own] & (i_rd_addr[rd_own] == i_wr_addr[wr_own]);

  shmem_rr_channel #(.N(COUNT), .MAX_BURST(MAX_BURST)) u_rd (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .req   (i_rd_req),
    .lock  (rd_lock),
    .mask  (hazard),
    .gnt   (o_rd_gnt),
    .owner (rd_own),
    .beat  (rd_beat)
  );

  shmem_rr_channel #(.N(COUNT), .MAX_BURST(MAX_BURST)) u_wr (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .req   (i_wr_req),
    .lock  (wr_lock),
    .mask  (1'b0),
    .gnt   (o_wr_gnt),
    .owner (wr_own),
    .beat  (wr_beat)
  );

  assign o_mem_wr_en   = wr_beat;
  assign o_mem_wr_addr = wr_beat ? i_wr_addr[wr_own] : '0;
  assign o_mem_wr_data = wr_beat ? i_wr_data[wr_own] : '0;
  assign o_mem_rd_addr = rd_beat ? i_rd_addr[rd_own] : '0;

  // Read response pipe: owner travels with the beat so handover cannot misroute it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_vld_q <= 1'b0;
      rd_own_q <= '0;
    end else begin
      rd_vld_q <= rd_beat;
      rd_own_q <= rd_own;
    end
  end

  // Decode the response owner into the one-hot valid.
  always_comb begin
    o_rd_vld = '0;
    for (int i = 0; i < COUNT; i++) begin
      o_rd_vld[i] = rd_vld_q && (rd_own_q == OW'(i));
    end
  end

  assign o_rd_data = rd_vld_q ? i_mem_rd_data : '0;

endmodule

// File: tb/tb_shmem_port_sched.sv
// Self-checking bench for shmem_port_sched: directed scenarios plus a random
// phase, all checked cycle by cycle against a behavioural reference model.
module tb_shmem_port_sched;
  import shmem_pkg::*;

  localparam int N  = 4;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] rd_req = '0, wr_req = '0, rd_lock = '0, wr_lock = '0;
  logic [N-1:0] rd_gnt, rd_vld, wr_gnt;
  addr_t rd_addr [N];
  addr_t wr_addr [N];
  data_t wr_data [N];
  data_t rd_data, mem_wr_data, mem_rd_q;
  addr_t mem_rd_addr, mem_wr_addr;
  logic  mem_wr_en;

  int n_chk = 0;
  int n_err = 0;

  shmem_port_sched #(.COUNT(N), .BUS_SIZE(128), .ADDR_W(8), .MAX_BURST(MB)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_rd_req      (rd_req),
    .i_rd_addr     (rd_addr),
    .o_rd_gnt      (rd_gnt),
    .o_rd_vld      (rd_vld),
    .o_rd_data     (rd_data),
    .i_wr_req      (wr_req),
    .i_wr_addr     (wr_addr),
    .i_wr_data     (wr_data),
    .o_wr_gnt      (wr_gnt),
`ifdef SHMEM_LOCK_EN
    .i_rd_lock     (rd_lock),
    .i_wr_lock     (wr_lock),
`endif
    .o_mem_rd_addr (mem_rd_addr),
    .i_mem_rd_data (mem_rd_q),
    .o_mem_wr_addr (mem_wr_addr),
    .o_mem_wr_data (mem_wr_data),
    .o_mem_wr_en   (mem_wr_en)
  );

  function automatic data_t init_val(input addr_t a);
    return {4{24'hC0DE00, a}};
  endfunction

  // Scratchpad: 1-cycle read latency, unwritten words return init_val.
  data_t bmem [256];
  bit    bwr  [256];
  always @(posedge clk) begin
    if (mem_wr_en) begin
      bmem[mem_wr_addr] <= mem_wr_data;
      bwr[mem_wr_addr]  <= 1'b1;
    end
    mem_rd_q <= bwr[mem_rd_addr] ? bmem[mem_rd_addr] : init_val(mem_rd_addr);
  end

  // Reference model: owner index per channel (-1 = nobody granted).
  int    rg, wg, rrun, wrun, rptr, wptr, e_own;
  bit    e_vld, rbeat, wbeat, haz;
  data_t e_data;
  data_t mmem [256];
  bit    mwr  [256];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int start, input int skip);
    for (int i = 0; i < N; i++) begin
      int k;
      k = (start + i) % N;
      if (k != skip && r[2'(k)]) return k;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] oh(input int g);
    return (g >= 0) ? 4'(1 << g) : 4'h0;
  endfunction

  task automatic model_reset();
    rg = -1; wg = -1; rrun = 0; wrun = 0; rptr = 0; wptr = 0;
    e_vld = 1'b0; e_own = 0; e_data = '0;
  endtask

  task automatic model_check();
    wbeat = (wg >= 0) && wr_req[2'(wg)];
    haz   = wbeat && (rg >= 0) && rd_req[2'(rg)] && (rd_addr[2'(rg)] == wr_addr[2'(wg)]);
    rbeat = (rg >= 0) && !haz && rd_req[2'(rg)];
    chk("rd_gnt", rd_gnt, haz ? 4'h0 : oh(rg));
    chk("wr_gnt", wr_gnt, oh(wg));
    chk("wr_en", mem_wr_en, wbeat);
    if (wbeat) begin
      chk("wr_addr", mem_wr_addr, wr_addr[2'(wg)]);
      chk("wr_data", mem_wr_data, wr_data[2'(wg)]);
    end
    if (rbeat) chk("rd_addr", mem_rd_addr, rd_addr[2'(rg)]);
    chk("rd_vld", rd_vld, e_vld ? oh(e_own) : 4'h0);
    if (e_vld) chk("rd_data", rd_data, e_data);
  endtask

  task automatic chan_next(inout int g, inout int run, inout int ptr,
                           input logic [N-1:0] req, input logic [N-1:0] lock, input bit beat);
    if (g < 0) begin
      if (req != 0) begin
        g   = pick(req, ptr, -1);
        run = 0;
      end
    end else if (!lock[2'(g)] && (!req[2'(g)] || (beat && run + 1 >= MB))) begin
      ptr = (g + 1) % N;
      g   = pick(req, ptr, g);
      run = 0;
    end else if (beat) begin
      run++;
    end
  endtask

  task automatic model_advance();
    addr_t a;
    e_vld = rbeat;
    e_own = rg;
    if (rbeat) begin
      a      = rd_addr[2'(rg)];
      e_data = mwr[a] ? mmem[a] : init_val(a);
    end
    if (wbeat) begin
      a       = wr_addr[2'(wg)];
      mmem[a] = wr_data[2'(wg)];
      mwr[a]  = 1'b1;
    end
    chan_next(rg, rrun, rptr, rd_req, rd_lock, rbeat);
    chan_next(wg, wrun, wptr, wr_req, wr_lock, wbeat);
  endtask

  // One cycle: settle, compare, advance the model, move past the next edge.
  task automatic step();
    #1;
    model_check();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset: outputs must clear at once, before any clock edge.
  task automatic do_reset();
    rst_n = 1'b0;
    rd_req = '0; wr_req = '0; rd_lock = '0; wr_lock = '0;
    #1;
    chk("rst_rd_gnt", rd_gnt, 4'h0);
    chk("rst_wr_gnt", wr_gnt, 4'h0);
    chk("rst_rd_vld", rd_vld, 4'h0);
    chk("rst_wr_en", mem_wr_en, 1'b0);
    chk("rst_rd_addr", mem_rd_addr, 8'h0);
    chk("rst_wr_data", mem_wr_data, 128'h0);
    chk("rst_rd_data", rd_data, 128'h0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1 [8];
    t1 = '{0, 1, 1, 1, 1, 0, 1, 1};
    foreach (rd_addr[i]) begin
      rd_addr[i] = '0; wr_addr[i] = '0; wr_data[i] = '0;
    end
    @(posedge clk);
    #1;

    // 1: lone reader, burst of MB then a one-cycle gap
    do_reset();
    foreach (rd_addr[i]) rd_addr[i] = 8'd5;
    rd_req = 4'b0001;
    for (int c = 0; c < 8; c++) begin
      #1 chk("t1_gnt", rd_gnt, t1[c] ? 4'b0001 : 4'b0000);
      step();
    end

    // 2: all readers, rotation 0,1,2,3,0 with MB beats each
    do_reset();
    rd_req = 4'b1111;
    for (int c = 0; c < 21; c++) begin
      #1 chk("t2_order", rd_gnt, (c == 0) ? 4'h0 : 4'(1 << (((c - 1) / 4) % 4)));
      step();
    end

    // 3: write/read same address in the same cycle
    do_reset();
    wr_addr[1] = 8'd7; wr_data[1] = {16{8'hA5}}; rd_addr[2] = 8'd7;
    wr_req = 4'b0010; rd_req = 4'b0100;
    step();
    #1 chk("t3_masked", rd_gnt, 4'h0);
    chk("t3_wen", mem_wr_en, 1'b1);
    step();
    wr_req = 4'b0000;
    #1 chk("t3_slip", rd_gnt, 4'b0100);
    step();
    rd_req = 4'b0000;
    #1 chk("t3_vld", rd_vld, 4'b0100);
    chk("t3_data", rd_data, {16{8'hA5}});
    step();

    // 4: owner drops request mid-burst with others pending
    do_reset();
    foreach (rd_addr[i]) rd_addr[i] = 8'd3;
    rd_req = 4'b1000;
    step();
    rd_req = 4'b1001;
    step();
    step();
    rd_req = 4'b0001;
    #1 chk("t4_hold", rd_gnt, 4'b1000);
    step();
    #1 chk("t4_regrant", rd_gnt, 4'b0001);
    chk("t4_novld", rd_vld, 4'h0);
    step();
    step();

    // 5: reset mid-burst with a read response pending
    rd_req = 4'b0001;
    step();
    step();
    #1 chk("t5_pending", rd_vld, 4'b0001);
    do_reset();
    rd_req = 4'b1111;
    step();
    #1 chk("t5_port0", rd_gnt, 4'b0001);
    step();

`ifdef SHMEM_LOCK_EN
    // 6: locked owner ignores burst limit and holds through idle cycles
    do_reset();
    rd_lock = 4'b0100;
    rd_req  = 4'b0100;
    step();
    rd_req = 4'b0101;
    for (int c = 0; c < 10; c++) begin
      #1 chk("t6_burst", rd_gnt, 4'b0100);
      step();
    end
    rd_req = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      #1 chk("t6_hold", rd_gnt, 4'b0100);
      step();
    end
    rd_lock = 4'b0000;
    step();
    #1 chk("t6_release", rd_gnt, 4'b0001);
    step();
`endif

    // Random traffic with a small address range to provoke hazards
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if (c == 700) do_reset();
      for (int p = 0; p < N; p++) begin
        if ($urandom_range(0, 3) == 0) rd_req[p] = ~rd_req[p];
        if ($urandom_range(0, 3) == 0) wr_req[p] = ~wr_req[p];
        rd_addr[p] = 8'($urandom_range(0, 7));
        wr_addr[p] = 8'($urandom_range(0, 7));
        wr_data[p] = {$urandom, $urandom, $urandom, $urandom};
      end
`ifdef SHMEM_LOCK_EN
      if ($urandom_range(0, 15) == 0) rd_lock[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 15) == 0) wr_lock[$urandom_range(0, 3)] ^= 1'b1;
`endif
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
